// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and its hazard controller:
// hazard/interrupt status in, register enables/flushes and PC select out.
interface pipeline_hazard_ctrl_if #(
   parameter int N_INTS = 3
);
   logic              load_use;
   logic              branch_taken_ex;
   logic              eret_ex;
   logic              halt_wb;
   logic              resume;
   logic [N_INTS-1:0] ints_req;

   logic              pc_en;
   logic [1:0]        pc_sel;
   logic              if_id_en;
   logic              if_id_stall;
   logic              if_id_clr;
   logic              id_ex_en;
   logic              id_ex_clr;
   logic              ex_dm_en;
   logic              ex_dm_clr;
   logic              dm_wb_en;
   logic              dm_wb_clr;
   logic              epc_we;
   logic              int_accept;
   logic [1:0]        int_vec;
   logic              inting;

   modport master (
      output load_use, branch_taken_ex, eret_ex, halt_wb, resume, ints_req,
      input  pc_en, pc_sel, if_id_en, if_id_stall, if_id_clr, id_ex_en, id_ex_clr,
             ex_dm_en, ex_dm_clr, dm_wb_en, dm_wb_clr, epc_we, int_accept,
             int_vec, inting
   );

   modport slave (
      input  load_use, branch_taken_ex, eret_ex, halt_wb, resume, ints_req,
      output pc_en, pc_sel, if_id_en, if_id_stall, if_id_clr, id_ex_en, id_ex_clr,
             ex_dm_en, ex_dm_clr, dm_wb_en, dm_wb_clr, epc_we, int_accept,
             int_vec, inting
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register / PC-source control for a 5-stage pipeline: load-use
// bubbles, branch and eret flushes, halt freeze and drained interrupt entry.
module pipeline_hazard_ctrl #(
   parameter int DRAIN_CYCLES = 2,
   parameter int N_INTS       = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pipeline_hazard_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {RUN, DRAIN, ENTER, HALTED} state_e;
   typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_EPC, PC_VECTOR} pc_sel_e;

   state_e            state;
   logic [N_INTS-1:0] pend;
   logic [N_INTS-1:0] pend_clr;
   logic [2:0]        cnt;
   logic              inting;
   logic [1:0]        int_vec;
   logic [1:0]        pri_idx;
   logic              accept;
   pc_sel_e           pc_sel;

   assign hz.pc_sel  = pc_sel;
   assign hz.inting  = inting;
   assign hz.int_vec = int_vec;

   // Lowest-numbered pending source wins, so scan downward and let the last hit stand.
   always_comb begin
      pri_idx = 2'd0;
      for (int i = N_INTS - 1; i >= 0; i--)
         if (pend[i]) pri_idx = 2'(i);
   end

   always_comb begin
      // NOTE: every output gets its idle value first so no path through the case infers a latch.
      hz.pc_en       = 1'b1;
      pc_sel         = PC_SEQ;
      hz.if_id_en    = 1'b1;
      hz.if_id_stall = 1'b0;
      hz.if_id_clr   = 1'b1;
      hz.id_ex_en    = 1'b1;
      hz.id_ex_clr   = 1'b1;
      hz.ex_dm_en    = 1'b1;
      hz.ex_dm_clr   = 1'b1;
      hz.dm_wb_en    = 1'b1;
      hz.dm_wb_clr   = 1'b1;
      hz.epc_we      = 1'b0;
      hz.int_accept  = 1'b0;
      accept         = 1'b0;
      pend_clr       = '0;

      unique case (state)
         RUN: begin
            if (hz.halt_wb) begin
               hz.pc_en    = 1'b0;
               hz.if_id_en = 1'b0;
               hz.id_ex_en = 1'b0;
               hz.ex_dm_en = 1'b0;
               hz.dm_wb_en = 1'b0;
            end else if (hz.eret_ex) begin
               pc_sel       = PC_EPC;
               hz.if_id_clr = 1'b0;
               hz.id_ex_clr = 1'b0;
            end else if (hz.branch_taken_ex) begin
               pc_sel       = PC_BRANCH;
               hz.if_id_clr = 1'b0;
               hz.id_ex_clr = 1'b0;
            end else if (|pend && !inting && !hz.load_use) begin
               accept       = 1'b1;
               hz.epc_we    = 1'b1;
               hz.pc_en     = 1'b0;
               hz.if_id_clr = 1'b0;
               hz.id_ex_clr = 1'b0;
            end else if (hz.load_use) begin
               hz.pc_en       = 1'b0;
               hz.if_id_stall = 1'b1;
               hz.id_ex_clr   = 1'b0;
            end
         end
         DRAIN: begin
            hz.pc_en = 1'b0;
            if (hz.halt_wb) begin
               hz.if_id_en = 1'b0;
               hz.id_ex_en = 1'b0;
               hz.ex_dm_en = 1'b0;
               hz.dm_wb_en = 1'b0;
            end else begin
               hz.if_id_clr = 1'b0;
               hz.id_ex_clr = 1'b0;
            end
         end
         ENTER: begin
            pc_sel        = PC_VECTOR;
            hz.if_id_clr  = 1'b0;
            hz.id_ex_clr  = 1'b0;
            hz.int_accept = 1'b1;
            for (int i = 0; i < N_INTS; i++)
               if (int_vec == 2'(i)) pend_clr[i] = 1'b1;
         end
         HALTED: begin
            // The resume cycle already decodes as idle.
            if (!hz.resume) begin
               hz.pc_en    = 1'b0;
               hz.if_id_en = 1'b0;
               hz.id_ex_en = 1'b0;
               hz.ex_dm_en = 1'b0;
               hz.dm_wb_en = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         pend    <= '0;
         cnt     <= '0;
         inting  <= 1'b0;
         int_vec <= 2'd0;
      end else begin
         // A request arriving while its source is being accepted keeps it pending.
         pend <= (pend & ~pend_clr) | hz.ints_req;
         unique case (state)
            RUN: begin
               if (hz.halt_wb) begin
                  state <= HALTED;
               end else if (hz.eret_ex) begin
                  inting <= 1'b0;
               end else if (accept) begin
                  int_vec <= pri_idx;
                  cnt     <= 3'(DRAIN_CYCLES - 1);
                  state   <= DRAIN;
               end
            end
            DRAIN: begin
               if (hz.halt_wb)     state <= HALTED;
               else if (cnt == '0) state <= ENTER;
               else                cnt   <= cnt - 3'd1;
            end
            ENTER: begin
               inting <= 1'b1;
               state  <= RUN;
            end
            HALTED: begin
               if (hz.resume) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (DRAIN_CYCLES=2, N_INTS=3)
// with hand-written sequences for reset during drain and interrupt latency.
module tb_pipeline_hazard_ctrl;

   typedef struct packed {
      logic       lu;
      logic       br;
      logic       er;
      logic       ht;
      logic       rs;
      logic [2:0] ir;
   } in_t;

   typedef struct packed {
      logic       pc_en;
      logic [1:0] pc_sel;
      logic       if_id_en;
      logic       if_id_stall;
      logic       if_id_clr;
      logic       id_ex_en;
      logic       id_ex_clr;
      logic       ex_dm_en;
      logic       ex_dm_clr;
      logic       dm_wb_en;
      logic       dm_wb_clr;
      logic       epc_we;
      logic       int_accept;
      logic [1:0] int_vec;
      logic       inting;
   } outs_t;

   typedef struct {
      in_t   i;
      outs_t e;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t vecs[$];

   pipeline_hazard_ctrl_if #(.N_INTS(3)) hz();

   pipeline_hazard_ctrl #(.DRAIN_CYCLES(2), .N_INTS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz.slave)
   );

   always #5 clk = ~clk;

   function automatic in_t mk_in(logic lu, logic br, logic er, logic ht, logic rs, logic [2:0] ir);
      in_t v;
      v.lu = lu; v.br = br; v.er = er; v.ht = ht; v.rs = rs; v.ir = ir;
      return v;
   endfunction

   function automatic outs_t o_idle(logic [1:0] iv, logic it);
      outs_t o;
      o = '{pc_en: 1'b1, pc_sel: 2'd0, if_id_en: 1'b1, if_id_stall: 1'b0, if_id_clr: 1'b1,
            id_ex_en: 1'b1, id_ex_clr: 1'b1, ex_dm_en: 1'b1, ex_dm_clr: 1'b1,
            dm_wb_en: 1'b1, dm_wb_clr: 1'b1, epc_we: 1'b0, int_accept: 1'b0,
            int_vec: iv, inting: it};
      return o;
   endfunction

   function automatic outs_t o_stall(logic [1:0] iv, logic it);
      outs_t o = o_idle(iv, it);
      o.pc_en = 1'b0; o.if_id_stall = 1'b1; o.id_ex_clr = 1'b0;
      return o;
   endfunction

   function automatic outs_t o_flush(logic [1:0] sel, logic [1:0] iv, logic it);
      outs_t o = o_idle(iv, it);
      o.pc_sel = sel; o.if_id_clr = 1'b0; o.id_ex_clr = 1'b0;
      return o;
   endfunction

   function automatic outs_t o_freeze(logic [1:0] iv, logic it);
      outs_t o = o_idle(iv, it);
      o.pc_en = 1'b0; o.if_id_en = 1'b0; o.id_ex_en = 1'b0;
      o.ex_dm_en = 1'b0; o.dm_wb_en = 1'b0;
      return o;
   endfunction

   function automatic outs_t o_drain(logic [1:0] iv, logic it);
      outs_t o = o_flush(2'd0, iv, it);
      o.pc_en = 1'b0;
      return o;
   endfunction

   function automatic outs_t o_accept(logic [1:0] iv, logic it);
      outs_t o = o_drain(iv, it);
      o.epc_we = 1'b1;
      return o;
   endfunction

   function automatic outs_t o_enter(logic [1:0] iv, logic it);
      outs_t o = o_flush(2'd3, iv, it);
      o.int_accept = 1'b1;
      return o;
   endfunction

   function automatic outs_t sample();
      outs_t o;
      o.pc_en = hz.pc_en; o.pc_sel = hz.pc_sel; o.if_id_en = hz.if_id_en;
      o.if_id_stall = hz.if_id_stall; o.if_id_clr = hz.if_id_clr;
      o.id_ex_en = hz.id_ex_en; o.id_ex_clr = hz.id_ex_clr;
      o.ex_dm_en = hz.ex_dm_en; o.ex_dm_clr = hz.ex_dm_clr;
      o.dm_wb_en = hz.dm_wb_en; o.dm_wb_clr = hz.dm_wb_clr;
      o.epc_we = hz.epc_we; o.int_accept = hz.int_accept;
      o.int_vec = hz.int_vec; o.inting = hz.inting;
      return o;
   endfunction

   task automatic add(input in_t i, input outs_t e);
      vec_t v;
      v.i = i; v.e = e;
      vecs.push_back(v);
   endtask

   task automatic apply(input in_t i);
      hz.load_use        = i.lu;
      hz.branch_taken_ex = i.br;
      hz.eret_ex         = i.er;
      hz.halt_wb         = i.ht;
      hz.resume          = i.rs;
      hz.ints_req        = i.ir;
   endtask

   task automatic check(input string name, input outs_t exp);
      outs_t act = sample();
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      in_t z;
      z = mk_in(0, 0, 0, 0, 0, 3'b000);

      // Idle / load-use / branch beating load_use
      add(z,                               o_idle(2'd0, 1'b0));
      add(mk_in(1, 0, 0, 0, 0, 3'b000),    o_stall(2'd0, 1'b0));
      add(z,                               o_idle(2'd0, 1'b0));
      add(mk_in(1, 1, 0, 0, 0, 3'b000),    o_flush(2'd1, 2'd0, 1'b0));
      add(z,                               o_idle(2'd0, 1'b0));
      // Two requests: source 1 first, source 2 after eret
      add(mk_in(0, 0, 0, 0, 0, 3'b110),    o_idle(2'd0, 1'b0));
      add(z,                               o_accept(2'd0, 1'b0));
      add(z,                               o_drain(2'd1, 1'b0));
      add(z,                               o_drain(2'd1, 1'b0));
      add(z,                               o_enter(2'd1, 1'b0));
      add(z,                               o_idle(2'd1, 1'b1));
      add(z,                               o_idle(2'd1, 1'b1));
      add(mk_in(0, 0, 1, 0, 0, 3'b000),    o_flush(2'd2, 2'd1, 1'b1));
      add(z,                               o_accept(2'd1, 1'b0));
      add(z,                               o_drain(2'd2, 1'b0));
      add(z,                               o_drain(2'd2, 1'b0));
      add(z,                               o_enter(2'd2, 1'b0));
      add(mk_in(0, 0, 1, 0, 0, 3'b000),    o_flush(2'd2, 2'd2, 1'b1));
      add(z,                               o_idle(2'd2, 1'b0));
      // Request coinciding with a branch is deferred one cycle
      add(mk_in(0, 1, 0, 0, 0, 3'b001),    o_flush(2'd1, 2'd2, 1'b0));
      add(z,                               o_accept(2'd2, 1'b0));
      add(z,                               o_drain(2'd0, 1'b0));
      add(z,                               o_drain(2'd0, 1'b0));
      add(z,                               o_enter(2'd0, 1'b0));
      add(mk_in(0, 0, 1, 0, 0, 3'b000),    o_flush(2'd2, 2'd0, 1'b1));
      add(z,                               o_idle(2'd0, 1'b0));
      // Halt in the first drain cycle, resume, re-accept same source
      add(mk_in(0, 0, 0, 0, 0, 3'b010),    o_idle(2'd0, 1'b0));
      add(z,                               o_accept(2'd0, 1'b0));
      add(mk_in(0, 0, 0, 1, 0, 3'b000),    o_freeze(2'd1, 1'b0));
      add(z,                               o_freeze(2'd1, 1'b0));
      add(mk_in(1, 1, 0, 0, 0, 3'b000),    o_freeze(2'd1, 1'b0));
      add(mk_in(0, 0, 0, 0, 1, 3'b000),    o_idle(2'd1, 1'b0));
      add(z,                               o_accept(2'd1, 1'b0));
      add(z,                               o_drain(2'd1, 1'b0));
      add(z,                               o_drain(2'd1, 1'b0));
      // Request still high in ENTER re-arms the pending bit
      add(mk_in(0, 0, 0, 0, 0, 3'b010),    o_enter(2'd1, 1'b0));
      add(z,                               o_idle(2'd1, 1'b1));
      add(mk_in(0, 0, 1, 0, 0, 3'b000),    o_flush(2'd2, 2'd1, 1'b1));
      add(z,                               o_accept(2'd1, 1'b0));
      add(z,                               o_drain(2'd1, 1'b0));
      add(z,                               o_drain(2'd1, 1'b0));
      add(z,                               o_enter(2'd1, 1'b0));
      add(mk_in(0, 0, 1, 0, 0, 3'b000),    o_flush(2'd2, 2'd1, 1'b1));
      add(z,                               o_idle(2'd1, 1'b0));
      // Halt from RUN; load_use ignored on the resume cycle
      add(mk_in(0, 0, 0, 1, 0, 3'b000),    o_freeze(2'd1, 1'b0));
      add(mk_in(1, 0, 0, 0, 1, 3'b000),    o_idle(2'd1, 1'b0));
      add(mk_in(1, 0, 0, 0, 0, 3'b000),    o_stall(2'd1, 1'b0));
      add(z,                               o_idle(2'd1, 1'b0));
      // Request deferred behind load_use
      add(mk_in(0, 0, 0, 0, 0, 3'b001),    o_idle(2'd1, 1'b0));
      add(mk_in(1, 0, 0, 0, 0, 3'b000),    o_stall(2'd1, 1'b0));
      add(z,                               o_accept(2'd1, 1'b0));

      apply(z);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_idle", o_idle(2'd0, 1'b0));
      @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[k]) begin
         apply(vecs[k].i);
         @(negedge clk);
         check($sformatf("vec%0d", k), vecs[k].e);
         @(posedge clk);
         #1;
      end

      // Controller is now in DRAIN for source 0; reset must return to idle at once.
      apply(z);
      @(negedge clk);
      check("drain_before_reset", o_drain(2'd0, 1'b0));
      #1 rst_n = 1'b0;
      #1 check("async_reset_mid_drain", o_idle(2'd0, 1'b0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("post_reset_idle%0d", c), o_idle(2'd0, 1'b0));
      end

      // Latency from request pulse to int_accept, bounded wait.
      begin
         int  lat = 0;
         bit  seen = 1'b0;
         logic [1:0] vec_seen = 2'd0;
         @(posedge clk);
         #1 apply(mk_in(0, 0, 0, 0, 0, 3'b100));
         @(posedge clk);
         #1 apply(z);
         for (int c = 1; c <= 10 && !seen; c++) begin
            @(negedge clk);
            if (hz.int_accept === 1'b1) begin
               seen = 1'b1;
               lat = c;
               vec_seen = hz.int_vec;
            end
            @(posedge clk);
            #1;
         end
         n_vec++;
         if (!seen || lat != 4) begin
            n_bad++;
            $display("FAIL accept_latency: got %0d (seen=%0d) expected 4", lat, seen);
         end
         n_vec++;
         if (vec_seen !== 2'd2) begin
            n_bad++;
            $display("FAIL accept_vec: got %0d expected 2", vec_seen);
         end
         @(negedge clk);
         check("after_entry", o_idle(2'd2, 1'b1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
